kv32_lsu: RTL



---
 rtl/kv32_lsu.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/kv32_lsu.sv
// rtl/kv32_lsu.sv - kv32 load/store unit: core request to word-aligned bus access with timeout
// Optional feature: define KV32_LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module kv32_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_we_q, bus_we_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_legal;
    logic [1:0]  req_off;
    logic [3:0]  req_strb;
    logic [31:0] req_wrep;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic        timeout_hit;

    // Request decode: legality, effective byte offset, strobes and lane replication.
    always_comb begin
        req_legal = 1'b0;
        req_off   = req_addr[1:0];
        req_strb  = 4'b0000;
        req_wrep  = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: begin
                req_legal = (req_funct3 == 3'b000) || !req_we;
                req_strb  = 4'b0001 << req_off;
                req_wrep  = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                req_legal = (req_funct3 == 3'b001) || !req_we;
`ifdef KV32_LSU_MISALIGN_TRAP_EN
                if (req_addr[0]) begin
                    req_legal = 1'b0;
                end
`else
                req_off[0] = 1'b0;
`endif
                req_strb  = 4'b0011 << req_off;
                req_wrep  = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                req_legal = 1'b1;
`ifdef KV32_LSU_MISALIGN_TRAP_EN
                if (req_addr[1:0] != 2'b00) begin
                    req_legal = 1'b0;
                end
`else
                req_off = 2'b00;
`endif
                req_strb  = 4'b1111;
            end
            default: begin
                req_legal = 1'b0;
            end
        endcase
    end

    // Load alignment and extension; funct3[2] selects zero-extension.
    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   rd_ext = {{24{rd_shift[7] & ~funct3_q[2]}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{rd_shift[15] & ~funct3_q[2]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Fires in the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d    = 32'd0;
                    funct3_d = req_funct3;
                    off_d    = req_off;
                    we_d     = req_we;
                    if (req_legal) begin
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_we_d    = req_we ? req_strb : 4'b0000;
                        bus_wdata_d = req_wrep;
                        state_d     = S_REQ;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = S_RSP;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = S_RSP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_rvalid) begin
                    rsp_err_d   = bus_err;
                    rsp_rdata_d = (bus_err || we_q) ? 32'd0 : rd_ext;
                    state_d     = S_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            we_q        <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_we_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign bus_valid = (state_q == S_REQ);
    assign rsp_valid = (state_q == S_RSP);
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
